// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package display_scan_ctrl_pkg;

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_ON   = 1'b1
    } scan_state_e;

    localparam int NUM_DIGITS = 4;
    localparam int NIB_W      = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int DIGITS_W   = NUM_DIGITS * NIB_W;

    localparam logic [NUM_DIGITS-1:0] DIG_OFF = 4'b1111;

    function automatic int timer_width(input int on_cycles, input int dead_cycles);
        int m;
        int w;
        m = (on_cycles > dead_cycles) ? on_cycles : dead_cycles;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// Loadable down-counter that stops at zero; used for dead/on slot timing.
module display_scan_ctrl_scan_timer #(
    parameter int W       = 4,
    parameter int RST_VAL = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= W'(RST_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit 7-segment scanner: dead-time gated slots, frame-aligned double
// buffering, per-digit blank and blink.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int ON_CYCLES    = 12500,
    parameter int DEAD_CYCLES  = 50,
    parameter int BLINK_FRAMES = 200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DIGITS_W-1:0]   digits_in,
    input  logic                  load,
    input  logic [NUM_DIGITS-1:0] blank_mask,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    output logic [NIB_W-1:0]      nibble,
    output logic [NUM_DIGITS-1:0] dig_n,
    output logic                  frame_done,
    output logic                  pending
);

    localparam int TW = timer_width(ON_CYCLES, DEAD_CYCLES);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [TW-1:0] ON_LOAD   = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] DEAD_LOAD = TW'(DEAD_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_FRAMES - 1);

    scan_state_e           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  tmr_load, tmr_zero;
    logic [TW-1:0]         tmr_val;
    logic [DIGITS_W-1:0]   active_q, active_d, pbuf_q, pbuf_d;
    logic                  pending_q, pending_d;
    logic                  blink_off_q, blink_off_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic                  vis_q, vis_d;
    logic [NIB_W-1:0]      nibble_q, nibble_d;
    logic [NUM_DIGITS-1:0] dig_n_q, dig_n_d;
    logic                  frame_done_q, frame_done_d;
    logic                  slot_end, boundary, dead_entry;

    display_scan_ctrl_scan_timer #(.W(TW), .RST_VAL(DEAD_CYCLES - 1)) u_scan_timer (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    assign slot_end   = (state_q == ST_ON) && tmr_zero;
    assign boundary   = enable && slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign dead_entry = !enable || slot_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_DEAD;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tmr_load = 1'b0;
        tmr_val  = DEAD_LOAD;
        if (!enable) begin
            state_d  = ST_DEAD;
            idx_d    = '0;
            tmr_load = 1'b1;
        end else if (tmr_zero) begin
            tmr_load = 1'b1;
            if (state_q == ST_DEAD) begin
                state_d = ST_ON;
                tmr_val = ON_LOAD;
            end else begin
                state_d = ST_DEAD;
                idx_d   = idx_q + 1'b1;
            end
        end
    end

    // A load on the commit edge (or while disabled) goes straight to active.
    always_comb begin
        active_d    = active_q;
        pbuf_d      = pbuf_q;
        pending_d   = pending_q;
        bcnt_d      = bcnt_q;
        blink_off_d = blink_off_q;
        if (!enable || boundary) begin
            if (load) begin
                active_d = digits_in;
            end else if (pending_q) begin
                active_d = pbuf_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pbuf_d    = digits_in;
            pending_d = 1'b1;
        end
        if (boundary) begin
            if (bcnt_q == BLINK_TOP) begin
                bcnt_d      = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    // Digit data and visibility are frozen at dead-time entry, using the
    // values that become current on that same edge.
    always_comb begin
        nibble_d = nibble_q;
        vis_d    = vis_q;
        if (dead_entry) begin
            nibble_d = active_d[{idx_d, 2'b00} +: NIB_W];
            vis_d    = ~blank_mask[idx_d] & ~(blink_mask[idx_d] & blink_off_d);
        end
        dig_n_d = DIG_OFF;
        if ((state_d == ST_ON) && vis_d) begin
            dig_n_d[idx_d] = 1'b0;
        end
        frame_done_d = boundary;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q     <= '0;
            pbuf_q       <= '0;
            pending_q    <= 1'b0;
            blink_off_q  <= 1'b0;
            bcnt_q       <= '0;
            vis_q        <= 1'b1;
            nibble_q     <= '0;
            dig_n_q      <= DIG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            active_q     <= active_d;
            pbuf_q       <= pbuf_d;
            pending_q    <= pending_d;
            blink_off_q  <= blink_off_d;
            bcnt_q       <= bcnt_d;
            vis_q        <= vis_d;
            nibble_q     <= nibble_d;
            dig_n_q      <= dig_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign nibble     = nibble_q;
    assign dig_n      = dig_n_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with ON=4, DEAD=2, BLINK_FRAMES=2.
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] digits_in = '0;
    logic        load = 1'b0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  blink_mask = '0;
    logic [3:0]  nibble;
    logic [3:0]  dig_n;
    logic        frame_done;
    logic        pending;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    display_scan_ctrl #(.ON_CYCLES(4), .DEAD_CYCLES(2), .BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .digits_in  (digits_in),
        .load       (load),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .nibble     (nibble),
        .dig_n      (dig_n),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    // Edges since the last reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic goto(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic lit(input int k, input logic [3:0] d, input logic [3:0] n);
        goto(k);
        chk("dig_n", 16'(dig_n), 16'(d));
        chk("nibble", 16'(nibble), 16'(n));
    endtask

    task automatic dig(input int k, input logic [3:0] d);
        goto(k);
        chk("dig_n", 16'(dig_n), 16'(d));
    endtask

    task automatic flag(input int k, input string tag, input logic got_sel, input logic exp);
        goto(k);
        chk(tag, 16'(got_sel ? frame_done : pending), 16'(exp));
    endtask

    always @(negedge clk) begin
        if (!reset) chk("onehot", 16'($countones(~dig_n) <= 1), 16'd1);
    end

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_dig_n", 16'(dig_n), 16'hF);
        chk("rst_nibble", 16'(nibble), 16'h0);
        chk("rst_frame_done", 16'(frame_done), 16'h0);
        chk("rst_pending", 16'(pending), 16'h0);

        digits_in = 16'h4321; load = 1'b1;
        goto(1); load = 1'b0;
        flag(1, "pending", 1'b0, 1'b1);
        lit(2, 4'hE, 4'h0);
        flag(23, "pending", 1'b0, 1'b1);
        flag(23, "frame_done", 1'b1, 1'b0);
        flag(24, "frame_done", 1'b1, 1'b1);
        flag(24, "pending", 1'b0, 1'b0);
        flag(25, "frame_done", 1'b1, 1'b0);
        lit(26, 4'hE, 4'h1);
        dig(29, 4'hE);
        dig(30, 4'hF);
        lit(32, 4'hD, 4'h2);
        lit(38, 4'hB, 4'h3);
        lit(44, 4'h7, 4'h4);
        flag(48, "frame_done", 1'b1, 1'b1);

        lit(50, 4'hE, 4'h1);
        digits_in = 16'h0005; load = 1'b1;
        goto(51); load = 1'b0;
        flag(51, "pending", 1'b0, 1'b1);
        goto(60); digits_in = 16'h0009; load = 1'b1;
        goto(61); load = 1'b0;
        flag(71, "pending", 1'b0, 1'b1);
        flag(72, "pending", 1'b0, 1'b0);
        flag(72, "frame_done", 1'b1, 1'b1);
        lit(74, 4'hE, 4'h9);
        lit(80, 4'hD, 4'h0);

        goto(95); digits_in = 16'h0007; load = 1'b1;
        goto(96); load = 1'b0;
        flag(96, "pending", 1'b0, 1'b0);
        flag(96, "frame_done", 1'b1, 1'b1);
        lit(98, 4'hE, 4'h7);

        goto(99); digits_in = 16'h0008; load = 1'b1;
        goto(100); load = 1'b0;
        flag(100, "pending", 1'b0, 1'b1);
        goto(119); digits_in = 16'h0003; load = 1'b1;
        goto(120); load = 1'b0;
        flag(120, "pending", 1'b0, 1'b0);
        lit(122, 4'hE, 4'h3);
        lit(146, 4'hE, 4'h3);

        goto(150); blank_mask = 4'b0100;
        dig(152, 4'hD);
        dig(158, 4'hF);
        dig(161, 4'hF);
        lit(164, 4'h7, 4'h0);
        goto(165); blank_mask = 4'b0000; blink_mask = 4'b0001;
        flag(168, "frame_done", 1'b1, 1'b1);
        dig(170, 4'hF);
        dig(176, 4'hD);
        lit(194, 4'hE, 4'h3);
        dig(218, 4'hE);
        dig(242, 4'hF);
        dig(266, 4'hF);
        dig(290, 4'hE);
        dig(296, 4'hD);

        goto(300); blink_mask = 4'b0000;
        dig(302, 4'hB);
        goto(303); enable = 1'b0;
        dig(304, 4'hF);
        flag(304, "frame_done", 1'b1, 1'b0);
        goto(305); digits_in = 16'hABCD; load = 1'b1;
        goto(306); load = 1'b0;
        flag(306, "pending", 1'b0, 1'b0);
        goto(310); enable = 1'b1;
        dig(311, 4'hF);
        lit(312, 4'hE, 4'hD);
        lit(318, 4'hD, 4'hC);
        flag(333, "frame_done", 1'b1, 1'b0);
        flag(334, "frame_done", 1'b1, 1'b1);

        goto(337);
        chk("pre_rst_dig_n", 16'(dig_n), 16'hE);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_dig_n", 16'(dig_n), 16'hF);
        chk("async_rst_nibble", 16'(nibble), 16'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
